rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//  In-order reorder buffer and retire stage of the 2-wide out-of-order RISC-V core. Sits downstream of the
//  complete stage. Allocates up to 2 entries per cycle for dispatch, marks entries done from 3 FU result ports,
//  and retires up to 2 completed entries per cycle in program order. Releases each retiree's old physical reg.
// PARAMETERS
//  ROB_DEPTH  16  entries; power of two; index width IDX_W = $clog2(ROB_DEPTH)
//  PREG_W     6   physical register index width (64 pregs)
//  DATA_W     32  result width
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous, active-low reset
//  alloc_req_1/_2   in   1       dispatch requests slot 1 / slot 2
//  alloc_type_1/_2  in   1       0=register write, 1=memory store
//  alloc_preg_1/_2  in   PREG_W  destination preg (store: address tag)
//  alloc_old_1/_2   in   PREG_W  preg previously mapped to the arch dest
//  alloc_ready      out  1       >=2 free entries (registered count)
//  alloc_idx_1/_2   out  IDX_W   ROB index granted (tail, tail+1), combinational
//  cmp_valid_k      in   1       k=1..3: FU result valid
//  cmp_idx_k        in   IDX_W   ROB index of that result
//  cmp_data_k       in   DATA_W  result value
//  ret_valid_1/_2   out  1       retire slot valid (slot 2 only with slot 1)
//  ret_type_1/_2    out  1       entry type
//  ret_preg_1/_2    out  PREG_W  committed destination preg
//  ret_data_1/_2    out  DATA_W  committed result
//  ret_free_1/_2    out  PREG_W  old preg to return to free pool
//  rob_count        out  IDX_W+1 occupied entries
//  rob_empty        out  1       rob_count==0
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, every entry v=0/comp=0; all ret_* outputs 0; alloc_ready=1; rob_empty=1.
//  - Entry fields: v, type, preg, old_preg, result, comp.
//  - Alloc: accepted only when alloc_ready=1; slot 2 honoured only with slot 1 (req_2 alone ignored).
//    Accepted entry: v=1, comp=0. Tail advances by accepted count, mod ROB_DEPTH.
//  - Complete: writes result and sets comp=1 on next edge, only if entry v=1; else ignored.
//    Same index on two ports in one cycle: lowest k wins.
//  - Retire: evaluated on registered state. Head retires if v&comp. Head+1 retires in the same cycle only if
//    the head retires and head+1 v&comp. ret_* registered: valid 1 cycle after the deciding edge, 0 otherwise.
//    Retired entries: v=0, comp=0. Head advances by retire count.
//  - Count: next = count + alloc - retire. alloc_ready = (ROB_DEPTH - count) >= 2 on current count.
//    A retire in the same cycle does not free space for that cycle's allocation.
//  - Wrap: pointers IDX_W bits, natural wrap 15->0. Full (count=16) -> alloc_ready=0, no entry overwritten.
//  - Empty: no retire. An alloc and a complete to the same index in one cycle: alloc wins (comp=0).
//  - rst_n low mid-operation: all state cleared immediately. In-flight completes are dropped.
// CONFIGURATION
//  ROB_CMP_BYPASS_EN defined: a result arriving on cmp_* for the head (or head+1) counts as complete
//    for this cycle's retire decision. Retire latency from result drops from 2 edges to 1.
//    ret_data carries the port data.
//  Undefined: a retire sees only comp bits already registered.
// STRUCTURE
//  Shared package: rob_entry_t packed struct, ROB_DEPTH/PREG_W/DATA_W constants, TYPE_REG/TYPE_MEM enum.
//  One sub-module: rob_retire_sel. Combinational; takes head entries (+ bypass inputs) and outputs
//  retire count 0..2 and slot selects.
//  Entry array, pointers and count live in rob_retire.
// TESTING
//  1 Reset, then alloc 2 (preg 33/34, old 5/6) -> alloc_idx 0/1. Complete idx1 then idx0 ->
//    ret_valid_1/_2 in one cycle, ret_free 5,6.
//  2 Alloc 16 with no completes -> alloc_ready=0 at count 16. 17th req ignored; count stays 16.
//  3 Wrap: run 20 alloc/complete/retire in order -> alloc_idx 15 then 0. Retire order matches alloc order.
//  4 Complete idx3 only while head=2 incomplete -> no retire. Complete idx2 -> idx2 and idx3 retire together.
//  5 cmp_1 and cmp_3 both hit idx4 with data 0xAA/0xBB -> retired data 0xAA. Complete to free idx -> no effect.
//  6 rst_n low with count=7 -> outputs zero at once, rob_empty=1. With ROB_CMP_BYPASS_EN, head
//    completes and retires one edge after cmp_valid.

Source files
------------

// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the rob_retire reorder buffer and its retire selector.
package rob_retire_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;
  localparam int DATA_W    = 32;
  localparam int RET_CNT_W = 2;

  typedef enum logic {
    TYPE_REG = 1'b0,
    TYPE_MEM = 1'b1
  } rob_type_e;

  typedef struct packed {
    logic              v;
    rob_type_e         typ;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic [DATA_W-1:0] result;
    logic              comp;
  } rob_entry_t;

  // Space for a full dispatch pair, judged on the occupancy of the current cycle only.
  function automatic logic has_room(input logic [IDX_W:0] cnt);
    logic [IDX_W:0] free_slots;
    free_slots = (IDX_W+1)'(ROB_DEPTH) - cnt;
    return free_slots >= (IDX_W+1)'(2);
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: decides how many of the two oldest entries retire this cycle, strictly in order.
module rob_retire_sel
  import rob_retire_pkg::*;
(
  input  logic                 i_head_v,
  input  logic                 i_head_comp,
  input  logic                 i_head_byp,
  input  logic                 i_next_v,
  input  logic                 i_next_comp,
  input  logic                 i_next_byp,
  output logic [RET_CNT_W-1:0] o_ret_cnt,
  output logic                 o_sel_1,
  output logic                 o_sel_2
);

  logic w_head_done;
  logic w_next_done;

  // Head+1 may only go when the head goes in the same cycle.
  always_comb begin
    w_head_done = i_head_v & (i_head_comp | i_head_byp);
    w_next_done = i_next_v & (i_next_comp | i_next_byp);
    o_sel_1     = w_head_done;
    o_sel_2     = w_head_done & w_next_done;
    o_ret_cnt   = {1'b0, o_sel_1} + {1'b0, o_sel_2};
  end

endmodule

// File: rtl/rob_retire.sv
// rob_retire: in-order ROB with 2-wide allocate, 3 result ports and 2-wide registered retire.
// Optional macro ROB_CMP_BYPASS_EN lets same-cycle results complete the head pair for retire.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc_req_1,
  input  logic              i_alloc_req_2,
  input  logic              i_alloc_type_1,
  input  logic              i_alloc_type_2,
  input  logic [PREG_W-1:0] i_alloc_preg_1,
  input  logic [PREG_W-1:0] i_alloc_preg_2,
  input  logic [PREG_W-1:0] i_alloc_old_1,
  input  logic [PREG_W-1:0] i_alloc_old_2,
  output logic              o_alloc_ready,
  output logic [IDX_W-1:0]  o_alloc_idx_1,
  output logic [IDX_W-1:0]  o_alloc_idx_2,
  input  logic              i_cmp_valid_1,
  input  logic              i_cmp_valid_2,
  input  logic              i_cmp_valid_3,
  input  logic [IDX_W-1:0]  i_cmp_idx_1,
  input  logic [IDX_W-1:0]  i_cmp_idx_2,
  input  logic [IDX_W-1:0]  i_cmp_idx_3,
  input  logic [DATA_W-1:0] i_cmp_data_1,
  input  logic [DATA_W-1:0] i_cmp_data_2,
  input  logic [DATA_W-1:0] i_cmp_data_3,
  output logic              o_ret_valid_1,
  output logic              o_ret_valid_2,
  output logic              o_ret_type_1,
  output logic              o_ret_type_2,
  output logic [PREG_W-1:0] o_ret_preg_1,
  output logic [PREG_W-1:0] o_ret_preg_2,
  output logic [DATA_W-1:0] o_ret_data_1,
  output logic [DATA_W-1:0] o_ret_data_2,
  output logic [PREG_W-1:0] o_ret_free_1,
  output logic [PREG_W-1:0] o_ret_free_2,
  output logic [IDX_W:0]    o_rob_count,
  output logic              o_rob_empty
);

  rob_entry_t           r_rob     [ROB_DEPTH];
  rob_entry_t           w_rob_nxt [ROB_DEPTH];
  logic [IDX_W-1:0]     r_head, r_tail, w_head_1;
  logic [IDX_W:0]       r_count, w_count_nxt;
  logic                 r_alloc_ready, r_empty;
  logic                 w_acc_1, w_acc_2;
  logic [1:0]           w_acc_cnt;
  logic [RET_CNT_W-1:0] w_ret_cnt;
  logic                 w_sel_1, w_sel_2, w_head_byp, w_next_byp;
  logic [DATA_W-1:0]    w_data_1, w_data_2;
  logic                 w_cmp_v    [3];
  logic [IDX_W-1:0]     w_cmp_idx  [3];
  logic [DATA_W-1:0]    w_cmp_data [3];
  logic                 r_ret_valid_1, r_ret_valid_2, r_ret_type_1, r_ret_type_2;
  logic [PREG_W-1:0]    r_ret_preg_1, r_ret_preg_2, r_ret_free_1, r_ret_free_2;
  logic [DATA_W-1:0]    r_ret_data_1, r_ret_data_2;

  assign w_cmp_v[0]    = i_cmp_valid_1;
  assign w_cmp_v[1]    = i_cmp_valid_2;
  assign w_cmp_v[2]    = i_cmp_valid_3;
  assign w_cmp_idx[0]  = i_cmp_idx_1;
  assign w_cmp_idx[1]  = i_cmp_idx_2;
  assign w_cmp_idx[2]  = i_cmp_idx_3;
  assign w_cmp_data[0] = i_cmp_data_1;
  assign w_cmp_data[1] = i_cmp_data_2;
  assign w_cmp_data[2] = i_cmp_data_3;

  assign w_head_1      = r_head + IDX_W'(1);
  assign o_alloc_idx_1 = r_tail;
  assign o_alloc_idx_2 = r_tail + IDX_W'(1);
  assign w_acc_1       = i_alloc_req_1 & r_alloc_ready;
  assign w_acc_2       = w_acc_1 & i_alloc_req_2;
  assign w_acc_cnt     = {1'b0, w_acc_1} + {1'b0, w_acc_2};
  assign w_count_nxt   = r_count + (IDX_W+1)'(w_acc_cnt) - (IDX_W+1)'(w_ret_cnt);

`ifdef ROB_CMP_BYPASS_EN
  logic [2:0] w_hit_h, w_hit_n;

  // Result-port hits on the head pair; the lowest port wins when several match.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_hit_h[k] = w_cmp_v[k] & (w_cmp_idx[k] == r_head);
      w_hit_n[k] = w_cmp_v[k] & (w_cmp_idx[k] == w_head_1);
    end
  end

  assign w_head_byp = |w_hit_h;
  assign w_next_byp = |w_hit_n;
  assign w_data_1 = r_rob[r_head].comp ? r_rob[r_head].result :
                    w_hit_h[0] ? w_cmp_data[0] : w_hit_h[1] ? w_cmp_data[1] : w_cmp_data[2];
  assign w_data_2 = r_rob[w_head_1].comp ? r_rob[w_head_1].result :
                    w_hit_n[0] ? w_cmp_data[0] : w_hit_n[1] ? w_cmp_data[1] : w_cmp_data[2];
`else
  assign w_head_byp = 1'b0;
  assign w_next_byp = 1'b0;
  assign w_data_1   = r_rob[r_head].result;
  assign w_data_2   = r_rob[w_head_1].result;
`endif

  rob_retire_sel u_sel (
    .i_head_v    (r_rob[r_head].v),
    .i_head_comp (r_rob[r_head].comp),
    .i_head_byp  (w_head_byp),
    .i_next_v    (r_rob[w_head_1].v),
    .i_next_comp (r_rob[w_head_1].comp),
    .i_next_byp  (w_next_byp),
    .o_ret_cnt   (w_ret_cnt),
    .o_sel_1     (w_sel_1),
    .o_sel_2     (w_sel_2)
  );

  // Per-entry next state: allocate beats retire-clear beats complete (lowest port first).
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      w_rob_nxt[i] = r_rob[i];
      if (w_acc_1 && (IDX_W'(i) == r_tail)) begin
        w_rob_nxt[i] = '{v: 1'b1, typ: rob_type_e'(i_alloc_type_1), preg: i_alloc_preg_1,
                         old_preg: i_alloc_old_1, result: {DATA_W{1'b0}}, comp: 1'b0};
      end else if (w_acc_2 && (IDX_W'(i) == o_alloc_idx_2)) begin
        w_rob_nxt[i] = '{v: 1'b1, typ: rob_type_e'(i_alloc_type_2), preg: i_alloc_preg_2,
                         old_preg: i_alloc_old_2, result: {DATA_W{1'b0}}, comp: 1'b0};
      end else if ((w_sel_1 && (IDX_W'(i) == r_head)) || (w_sel_2 && (IDX_W'(i) == w_head_1))) begin
        w_rob_nxt[i] = '0;
      end else if (r_rob[i].v && w_cmp_v[0] && (w_cmp_idx[0] == IDX_W'(i))) begin
        w_rob_nxt[i].result = w_cmp_data[0];
        w_rob_nxt[i].comp   = 1'b1;
      end else if (r_rob[i].v && w_cmp_v[1] && (w_cmp_idx[1] == IDX_W'(i))) begin
        w_rob_nxt[i].result = w_cmp_data[1];
        w_rob_nxt[i].comp   = 1'b1;
      end else if (r_rob[i].v && w_cmp_v[2] && (w_cmp_idx[2] == IDX_W'(i))) begin
        w_rob_nxt[i].result = w_cmp_data[2];
        w_rob_nxt[i].comp   = 1'b1;
      end else begin
        w_rob_nxt[i] = r_rob[i];
      end
    end
  end

  // State and retire registers; idle retire slots drive all-zero payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_rob[i] <= '0;
      r_head        <= {IDX_W{1'b0}};
      r_tail        <= {IDX_W{1'b0}};
      r_count       <= {(IDX_W+1){1'b0}};
      r_alloc_ready <= 1'b1;
      r_empty       <= 1'b1;
      r_ret_valid_1 <= 1'b0;
      r_ret_valid_2 <= 1'b0;
      r_ret_type_1  <= 1'b0;
      r_ret_type_2  <= 1'b0;
      r_ret_preg_1  <= {PREG_W{1'b0}};
      r_ret_preg_2  <= {PREG_W{1'b0}};
      r_ret_free_1  <= {PREG_W{1'b0}};
      r_ret_free_2  <= {PREG_W{1'b0}};
      r_ret_data_1  <= {DATA_W{1'b0}};
      r_ret_data_2  <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) r_rob[i] <= w_rob_nxt[i];
      r_head        <= r_head + IDX_W'(w_ret_cnt);
      r_tail        <= r_tail + IDX_W'(w_acc_cnt);
      r_count       <= w_count_nxt;
      r_alloc_ready <= has_room(w_count_nxt);
      r_empty       <= (w_count_nxt == {(IDX_W+1){1'b0}});
      r_ret_valid_1 <= w_sel_1;
      r_ret_valid_2 <= w_sel_2;
      r_ret_type_1  <= w_sel_1 & (r_rob[r_head].typ == TYPE_MEM);
      r_ret_type_2  <= w_sel_2 & (r_rob[w_head_1].typ == TYPE_MEM);
      r_ret_preg_1  <= w_sel_1 ? r_rob[r_head].preg : {PREG_W{1'b0}};
      r_ret_preg_2  <= w_sel_2 ? r_rob[w_head_1].preg : {PREG_W{1'b0}};
      r_ret_free_1  <= w_sel_1 ? r_rob[r_head].old_preg : {PREG_W{1'b0}};
      r_ret_free_2  <= w_sel_2 ? r_rob[w_head_1].old_preg : {PREG_W{1'b0}};
      r_ret_data_1  <= w_sel_1 ? w_data_1 : {DATA_W{1'b0}};
      r_ret_data_2  <= w_sel_2 ? w_data_2 : {DATA_W{1'b0}};
    end
  end

  assign o_alloc_ready = r_alloc_ready;
  assign o_rob_count   = r_count;
  assign o_rob_empty   = r_empty;
  assign o_ret_valid_1 = r_ret_valid_1;
  assign o_ret_valid_2 = r_ret_valid_2;
  assign o_ret_type_1  = r_ret_type_1;
  assign o_ret_type_2  = r_ret_type_2;
  assign o_ret_preg_1  = r_ret_preg_1;
  assign o_ret_preg_2  = r_ret_preg_2;
  assign o_ret_free_1  = r_ret_free_1;
  assign o_ret_free_2  = r_ret_free_2;
  assign o_ret_data_1  = r_ret_data_1;
  assign o_ret_data_2  = r_ret_data_2;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed scenarios plus random traffic against a queue model.
// Honours ROB_CMP_BYPASS_EN the same way as the design build.
`timescale 1ns/1ps
module tb_rob_retire;

  logic        clk;
  logic        rst_n;
  logic        req1, req2, typ1, typ2;
  logic [5:0]  preg1, preg2, old1, old2;
  logic        cv [3];
  logic [3:0]  ci [3];
  logic [31:0] cd [3];
  logic        o_alloc_ready, o_ret_valid_1, o_ret_valid_2, o_ret_type_1, o_ret_type_2, o_rob_empty;
  logic [3:0]  o_alloc_idx_1, o_alloc_idx_2;
  logic [5:0]  o_ret_preg_1, o_ret_preg_2, o_ret_free_1, o_ret_free_2;
  logic [31:0] o_ret_data_1, o_ret_data_2;
  logic [4:0]  o_rob_count;

  typedef struct {
    logic [3:0]  idx;
    logic        typ;
    logic [5:0]  preg;
    logic [5:0]  old;
    bit          done;
    logic [31:0] data;
  } ment_t;

  ment_t mq[$];
  int    m_tail;
  int    n_chk;
  int    n_pass;

  rob_retire dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_req_1(req1), .i_alloc_req_2(req2), .i_alloc_type_1(typ1), .i_alloc_type_2(typ2),
    .i_alloc_preg_1(preg1), .i_alloc_preg_2(preg2), .i_alloc_old_1(old1), .i_alloc_old_2(old2),
    .o_alloc_ready(o_alloc_ready), .o_alloc_idx_1(o_alloc_idx_1), .o_alloc_idx_2(o_alloc_idx_2),
    .i_cmp_valid_1(cv[0]), .i_cmp_valid_2(cv[1]), .i_cmp_valid_3(cv[2]),
    .i_cmp_idx_1(ci[0]), .i_cmp_idx_2(ci[1]), .i_cmp_idx_3(ci[2]),
    .i_cmp_data_1(cd[0]), .i_cmp_data_2(cd[1]), .i_cmp_data_3(cd[2]),
    .o_ret_valid_1(o_ret_valid_1), .o_ret_valid_2(o_ret_valid_2),
    .o_ret_type_1(o_ret_type_1), .o_ret_type_2(o_ret_type_2),
    .o_ret_preg_1(o_ret_preg_1), .o_ret_preg_2(o_ret_preg_2),
    .o_ret_data_1(o_ret_data_1), .o_ret_data_2(o_ret_data_2),
    .o_ret_free_1(o_ret_free_1), .o_ret_free_2(o_ret_free_2),
    .o_rob_count(o_rob_count), .o_rob_empty(o_rob_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Lowest-numbered result port that targets idx, if any.
  function automatic bit cmp_hit(input logic [3:0] idx, output logic [31:0] d);
    d = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (cv[k] && ci[k] == idx) begin
        d = cd[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle();
    req1 = 1'b0; req2 = 1'b0; typ1 = 1'b0; typ2 = 1'b0;
    preg1 = 6'd0; preg2 = 6'd0; old1 = 6'd0; old2 = 6'd0;
    for (int k = 0; k < 3; k++) begin
      cv[k] = 1'b0; ci[k] = 4'd0; cd[k] = 32'h0;
    end
  endtask

  task automatic set_alloc(input logic r1, input logic r2, input logic [5:0] p1, input logic [5:0] p2,
                           input logic [5:0] o1, input logic [5:0] o2);
    req1 = r1; req2 = r2; preg1 = p1; preg2 = p2; old1 = o1; old2 = o2;
    typ1 = 1'($urandom_range(1)); typ2 = 1'($urandom_range(1));
  endtask

  // One clock: check pre-edge state, advance the model, check the retire outputs after the edge.
  task automatic step();
    int          n;
    bit          r1, r2, h;
    logic [31:0] d0, d1, bd;
    ment_t       e0, e1;
    n = mq.size();
    chk("count", 32'(o_rob_count), n);
    chk("empty", 32'(o_rob_empty), 32'(n == 0));
    chk("alloc_ready", 32'(o_alloc_ready), 32'((16 - n) >= 2));
    chk("alloc_idx_1", 32'(o_alloc_idx_1), m_tail);
    chk("alloc_idx_2", 32'(o_alloc_idx_2), (m_tail + 1) % 16);
    r1 = 1'b0; r2 = 1'b0; d0 = 32'h0; d1 = 32'h0;
    e0 = '{default: '0}; e1 = '{default: '0};
    if (n >= 1) begin
      e0 = mq[0]; h = e0.done; d0 = e0.data;
`ifdef ROB_CMP_BYPASS_EN
      if (!h && cmp_hit(e0.idx, bd)) begin h = 1'b1; d0 = bd; end
`endif
      r1 = h;
    end
    if (r1 && n >= 2) begin
      e1 = mq[1]; h = e1.done; d1 = e1.data;
`ifdef ROB_CMP_BYPASS_EN
      if (!h && cmp_hit(e1.idx, bd)) begin h = 1'b1; d1 = bd; end
`endif
      r2 = h;
    end
    foreach (mq[j]) begin
      if (cmp_hit(mq[j].idx, bd)) begin mq[j].done = 1'b1; mq[j].data = bd; end
    end
    if (r1) void'(mq.pop_front());
    if (r2) void'(mq.pop_front());
    if ((16 - n) >= 2 && req1) begin
      mq.push_back('{idx: 4'(m_tail), typ: typ1, preg: preg1, old: old1, done: 1'b0, data: 32'h0});
      m_tail = (m_tail + 1) % 16;
      if (req2) begin
        mq.push_back('{idx: 4'(m_tail), typ: typ2, preg: preg2, old: old2, done: 1'b0, data: 32'h0});
        m_tail = (m_tail + 1) % 16;
      end
    end
    @(posedge clk); #1;
    chk("ret_valid_1", 32'(o_ret_valid_1), 32'(r1));
    chk("ret_type_1", 32'(o_ret_type_1), r1 ? 32'(e0.typ) : 32'h0);
    chk("ret_preg_1", 32'(o_ret_preg_1), r1 ? 32'(e0.preg) : 32'h0);
    chk("ret_free_1", 32'(o_ret_free_1), r1 ? 32'(e0.old) : 32'h0);
    chk("ret_data_1", o_ret_data_1, r1 ? d0 : 32'h0);
    chk("ret_valid_2", 32'(o_ret_valid_2), 32'(r2));
    chk("ret_type_2", 32'(o_ret_type_2), r2 ? 32'(e1.typ) : 32'h0);
    chk("ret_preg_2", 32'(o_ret_preg_2), r2 ? 32'(e1.preg) : 32'h0);
    chk("ret_free_2", 32'(o_ret_free_2), r2 ? 32'(e1.old) : 32'h0);
    chk("ret_data_2", o_ret_data_2, r2 ? d1 : 32'h0);
  endtask

  task automatic rand_inputs(input int alloc_pct, input int cmp_pct);
    set_alloc(1'($urandom_range(99) < alloc_pct), 1'($urandom_range(1)),
              6'($urandom_range(63)), 6'($urandom_range(63)),
              6'($urandom_range(63)), 6'($urandom_range(63)));
    for (int k = 0; k < 3; k++) begin
      cv[k] = 1'($urandom_range(99) < cmp_pct);
      if (mq.size() > 0 && $urandom_range(9) < 8) ci[k] = mq[$urandom_range(mq.size() - 1)].idx;
      else ci[k] = 4'($urandom_range(15));
      cd[k] = $urandom;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_tail = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_alloc_ready), 32'd1);
    chk("rst_empty", 32'(o_rob_empty), 32'd1);
    chk("rst_count", 32'(o_rob_count), 32'd0);
    chk("rst_ret_valid", 32'(o_ret_valid_1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pair allocate, out-of-order completes, paired retire.
    chk("t1_idx_1", 32'(o_alloc_idx_1), 32'd0);
    chk("t1_idx_2", 32'(o_alloc_idx_2), 32'd1);
    set_alloc(1'b1, 1'b1, 6'd33, 6'd34, 6'd5, 6'd6);
    step();
    idle(); cv[0] = 1'b1; ci[0] = 4'd1; cd[0] = 32'h11;
    step();
    idle(); cv[0] = 1'b1; ci[0] = 4'd0; cd[0] = 32'h10;
    step();
    idle();
`ifndef ROB_CMP_BYPASS_EN
    step();
`endif
    chk("t1_v1", 32'(o_ret_valid_1), 32'd1);
    chk("t1_v2", 32'(o_ret_valid_2), 32'd1);
    chk("t1_free_1", 32'(o_ret_free_1), 32'd5);
    chk("t1_free_2", 32'(o_ret_free_2), 32'd6);
    step();

    // Head+1 complete alone must wait for the head.
    set_alloc(1'b1, 1'b1, 6'd40, 6'd41, 6'd7, 6'd8);
    step();
    idle(); cv[0] = 1'b1; ci[0] = 4'd3; cd[0] = 32'h33;
    step();
    idle();
    step();
    chk("t4_no_ret", 32'(o_ret_valid_1), 32'd0);
    cv[1] = 1'b1; ci[1] = 4'd2; cd[1] = 32'h22;
    step();
    idle();
`ifndef ROB_CMP_BYPASS_EN
    step();
`endif
    chk("t4_v1", 32'(o_ret_valid_1), 32'd1);
    chk("t4_v2", 32'(o_ret_valid_2), 32'd1);
    step();

    // Two ports on one index, plus a complete to an unallocated index.
    set_alloc(1'b1, 1'b1, 6'd42, 6'd43, 6'd9, 6'd10);
    step();
    idle();
    cv[0] = 1'b1; ci[0] = 4'd4; cd[0] = 32'hAA;
    cv[2] = 1'b1; ci[2] = 4'd4; cd[2] = 32'hBB;
    cv[1] = 1'b1; ci[1] = 4'd9; cd[1] = 32'h99;
    step();
    idle();
`ifndef ROB_CMP_BYPASS_EN
    step();
`endif
    chk("t5_data", o_ret_data_1, 32'hAA);
    chk("t5_v2", 32'(o_ret_valid_2), 32'd0);
    cv[0] = 1'b1; ci[0] = 4'd5; cd[0] = 32'h55;
    step();
    idle();
    repeat (2) step();

    // Fill to 16 without completes; the extra request is refused.
    for (int i = 0; i < 8; i++) begin
      set_alloc(1'b1, 1'b1, 6'(i * 2), 6'(i * 2 + 1), 6'(i + 20), 6'(i + 40));
      step();
    end
    chk("t2_full_count", 32'(o_rob_count), 32'd16);
    chk("t2_full_ready", 32'(o_alloc_ready), 32'd0);
    set_alloc(1'b1, 1'b1, 6'd63, 6'd62, 6'd61, 6'd60);
    step();
    idle();
    chk("t2_still_16", 32'(o_rob_count), 32'd16);
    step();
    chk("t2_no_ret", 32'(o_ret_valid_1), 32'd0);

    // Random traffic: wraps the pointers many times.
    for (int i = 0; i < 600; i++) begin
      rand_inputs(60, 45);
      step();
    end

    for (int it = 0; it < 100 && mq.size() > 0; it++) begin
      idle();
      cv[0] = 1'b1; ci[0] = mq[$urandom_range(mq.size() - 1)].idx; cd[0] = $urandom;
      cv[1] = 1'b1; ci[1] = mq[0].idx; cd[1] = $urandom;
      step();
    end
    idle();
    step();
    chk("drain_empty", 32'(o_rob_empty), 32'd1);

    // Eight in flight, retire one, then reset with a complete pending.
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 1'b1, 6'(i + 1), 6'(i + 11), 6'(i + 21), 6'(i + 31));
      step();
    end
    idle(); cv[0] = 1'b1; ci[0] = mq[0].idx; cd[0] = 32'h77;
    step();
    idle();
`ifndef ROB_CMP_BYPASS_EN
    step();
`endif
    chk("t6_pre_count", 32'(o_rob_count), 32'd7);
    chk("t6_pre_valid", 32'(o_ret_valid_1), 32'd1);
    cv[0] = 1'b1; ci[0] = mq[0].idx; cd[0] = 32'h78;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(o_rob_count), 32'd0);
    chk("t6_rst_empty", 32'(o_rob_empty), 32'd1);
    chk("t6_rst_ready", 32'(o_alloc_ready), 32'd1);
    chk("t6_rst_valid", 32'(o_ret_valid_1), 32'd0);
    chk("t6_rst_free", 32'(o_ret_free_1), 32'd0);
    chk("t6_rst_idx", 32'(o_alloc_idx_1), 32'd0);
    mq.delete();
    m_tail = 0;
    @(posedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Retire latency measured from the result cycle.
    set_alloc(1'b1, 1'b0, 6'd7, 6'd0, 6'd8, 6'd0);
    step();
    idle(); cv[0] = 1'b1; ci[0] = 4'd0; cd[0] = 32'h5A;
    step();
    idle();
`ifdef ROB_CMP_BYPASS_EN
    chk("t6_lat_edge1", 32'(o_ret_valid_1), 32'd1);
`else
    chk("t6_lat_edge1", 32'(o_ret_valid_1), 32'd0);
`endif
    step();
`ifdef ROB_CMP_BYPASS_EN
    chk("t6_lat_edge2", 32'(o_ret_valid_1), 32'd0);
`else
    chk("t6_lat_edge2", 32'(o_ret_valid_1), 32'd1);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
